// File: rtl/noc_flit_injector.sv
// Packetizing, credit-tracked flit injector for one CONNECT network send port.
// Buffers 64-bit payload words, stamps dest/vc/tail, and issues only while credit remains.
module noc_flit_injector #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         BUF_DEPTH  = 16,
  parameter logic [1:0] VC         = 2'd0
) (
  input  logic        sys_clk,
  input  logic        reset,
  // Producer stream: a word transfers on a rising edge where s_valid && s_ready;
  // s_ready depends only on FIFO occupancy, never on s_valid.
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  input  logic [4:0]  s_dest,
  input  logic        s_last,
  output logic [72:0] put_flit,
  output logic        en_put_flit,
  input  logic [2:0]  get_credits,
  output logic [4:0]  credits,
  output logic        credit_err,
  output logic        o_dbg_state
);

  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [4:0]     CRED_MAX = 5'(BUF_DEPTH);
  localparam logic [AW:0]    OCC_MAX  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {ST_HEAD = 1'b0, ST_BODY = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [4:0]    r_pkt_dest, w_dest;
  logic [69:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_occ;
  logic [4:0]    r_credits;
  logic          r_credit_err;
  logic [72:0]   r_put_flit;
  logic          r_en_put;
  logic          w_push, w_issue, w_cred_in;
  logic [69:0]   w_head;

  assign s_ready     = (r_occ < OCC_MAX);
  assign w_push      = s_valid && s_ready;
  assign w_issue     = (r_occ != '0) && (r_credits != '0);
  assign w_cred_in   = get_credits[2] && (get_credits[1:0] == VC);
  assign w_head      = r_mem[r_rd_ptr];

  assign put_flit    = r_put_flit;
  assign en_put_flit = r_en_put;
  assign credits     = r_credits;
  assign credit_err  = r_credit_err;
  assign o_dbg_state = r_state;

  // Only the head word carries a usable dest; body words reuse the latched one.
  always_comb begin
    w_state_nxt = r_state;
    w_dest      = r_pkt_dest;
    case (r_state)
      ST_HEAD: begin
        w_dest = s_dest;
        if (w_push && !s_last) w_state_nxt = ST_BODY;
      end
      ST_BODY: begin
        if (w_push && s_last) w_state_nxt = ST_HEAD;
      end
      default: w_state_nxt = ST_HEAD;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_HEAD;
      r_pkt_dest <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push && (r_state == ST_HEAD)) r_pkt_dest <= s_dest;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s_last, w_dest, s_data};
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_issue})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // A return that would exceed the router buffer depth is dropped and flagged.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_credits    <= CRED_MAX;
      r_credit_err <= 1'b0;
    end else if (w_cred_in && !w_issue) begin
      if (r_credits == CRED_MAX) r_credit_err <= 1'b1;
      else                       r_credits    <= r_credits + 1'b1;
    end else if (!w_cred_in && w_issue) begin
      r_credits <= r_credits - 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_en_put   <= 1'b0;
      r_put_flit <= '0;
    end else begin
      r_en_put   <= w_issue;
      r_put_flit <= w_issue ? {1'b1, w_head[69], w_head[68:64], VC, w_head[63:0]} : '0;
    end
  end

endmodule
